// File: rtl/sio_frame_gen.sv
// Serial frame generator: emits gap zeros, a start bit, DATA_W data bits
// and an optional parity bit, advancing one bit per rising edge of an
// external bit clock that is synchronised into the MCLK domain.
module sio_frame_gen #(
  parameter int DATA_W    = 10,
  parameter int GAP_W     = 5,
  parameter int PARITY    = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic              MCLK,
  input  logic              nRESET,
  input  logic              SioClk,
  output logic              SioDat,
  input  logic [DATA_W-1:0] TxData,
  input  logic              TxValid,
  output logic              TxAck,
  input  logic              Repeat,
  input  logic [GAP_W-1:0]  GapLen,
  output logic              Busy,
  output logic              FrameDone
);

  // One counter serves both the gap and the data phase, so it must hold
  // whichever of GapLen or DATA_W needs more bits.
  localparam int CNT_W = (GAP_W > $clog2(DATA_W + 1)) ? GAP_W : $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_GAP  = 2'd1,
    ST_DATA = 2'd2,
    ST_PAR  = 2'd3
  } state_t;

  // Even parity is the XOR of the word; odd parity is its inverse.
  function automatic logic f_parity(input logic [DATA_W-1:0] word);
    f_parity = (PARITY == 2) ? ~(^word) : (^word);
  endfunction

  logic              r_sync1, r_sync2, r_hist;
  logic              w_strobe;
  state_t            r_state, w_state_nx;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
  logic [DATA_W-1:0] r_shift, w_shift_nx;
  logic [DATA_W-1:0] r_last, w_last_nx;
  logic              r_have, w_have_nx;
  logic              r_par, w_par_nx;
  logic              r_dat, w_dat_nx;
  logic              r_busy, w_busy_nx;
  logic              r_ack, w_ack_nx;
  logic              r_done, w_done_nx;
  logic [CNT_W-1:0]  w_gap_load;
  logic [DATA_W-1:0] w_load_word;

  assign w_strobe    = r_sync2 & ~r_hist;
  assign w_gap_load  = CNT_W'(GapLen);
  // A fresh word always beats a repeat of the previous one.
  assign w_load_word = TxValid ? TxData : r_last;

  assign SioDat    = r_dat;
  assign TxAck     = r_ack;
  assign Busy      = r_busy;
  assign FrameDone = r_done;

  // Synchronise SioClk and keep one history bit for rising-edge detection.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= SioClk;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  // Frame state and all registered outputs.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_shift <= '0;
      r_last  <= '0;
      r_have  <= 1'b0;
      r_par   <= 1'b0;
      r_dat   <= 1'b0;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_shift <= w_shift_nx;
      r_last  <= w_last_nx;
      r_have  <= w_have_nx;
      r_par   <= w_par_nx;
      r_dat   <= w_dat_nx;
      r_busy  <= w_busy_nx;
      r_ack   <= w_ack_nx;
      r_done  <= w_done_nx;
    end
  end

  // Next-state logic: everything holds except on a bit-clock strobe;
  // the TxAck and FrameDone pulses clear on every other cycle.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_shift_nx = r_shift;
    w_last_nx  = r_last;
    w_have_nx  = r_have;
    w_par_nx   = r_par;
    w_dat_nx   = r_dat;
    w_busy_nx  = r_busy;
    w_ack_nx   = 1'b0;
    w_done_nx  = 1'b0;
    if (w_strobe) begin
      case (r_state)
        ST_INIT: begin
          w_dat_nx   = 1'b0;
          w_busy_nx  = 1'b0;
          w_cnt_nx   = w_gap_load;
          w_state_nx = ST_GAP;
        end
        ST_GAP: begin
          if (r_cnt != '0) begin
            w_dat_nx = 1'b0;
            w_cnt_nx = r_cnt - CNT_ONE;
          end else if (TxValid || (Repeat && r_have)) begin
            w_dat_nx   = 1'b1;
            w_busy_nx  = 1'b1;
            w_shift_nx = w_load_word;
            w_last_nx  = w_load_word;
            w_par_nx   = f_parity(w_load_word);
            w_have_nx  = 1'b1;
            w_ack_nx   = TxValid;
            w_cnt_nx   = CNT_DATA;
            w_state_nx = ST_DATA;
          end else begin
            w_dat_nx = 1'b0;
          end
        end
        ST_DATA: begin
          if (r_cnt != '0) begin
            if (MSB_FIRST != 0) begin
              w_dat_nx   = r_shift[DATA_W-1];
              w_shift_nx = r_shift << 1;
            end else begin
              w_dat_nx   = r_shift[0];
              w_shift_nx = r_shift >> 1;
            end
            w_cnt_nx = r_cnt - CNT_ONE;
          end else if (PARITY != 0) begin
            w_dat_nx   = r_par;
            w_state_nx = ST_PAR;
          end else begin
            w_dat_nx   = 1'b0;
            w_busy_nx  = 1'b0;
            w_done_nx  = 1'b1;
            w_cnt_nx   = w_gap_load;
            w_state_nx = ST_GAP;
          end
        end
        ST_PAR: begin
          w_dat_nx   = 1'b0;
          w_busy_nx  = 1'b0;
          w_done_nx  = 1'b1;
          w_cnt_nx   = w_gap_load;
          w_state_nx = ST_GAP;
        end
        default: begin
          w_dat_nx   = 1'b0;
          w_busy_nx  = 1'b0;
          w_state_nx = ST_INIT;
        end
      endcase
    end else begin
      w_state_nx = r_state;
    end
  end

endmodule

// File: tb/tb_sio_frame_gen.sv
// Bench for sio_frame_gen: DUT A uses default parameters, DUT B is an
// 8-bit LSB-first even-parity variant. Expected bit periods are queued
// per DUT and compared after each SioClk period.
module tb_sio_frame_gen;

  typedef struct packed {
    logic dat;
    logic busy;
    logic done;
    logic ack;
  } exp_t;

  logic       MCLK = 1'b0;
  logic       nRESET = 1'b0;
  logic       SioClk = 1'b0;

  logic [9:0] TxData_a = '0;
  logic       TxValid_a = 1'b0, Repeat_a = 1'b0;
  logic [4:0] GapLen_a = '0;
  logic       SioDat_a, TxAck_a, Busy_a, FrameDone_a;

  logic [7:0] TxData_b = '0;
  logic       TxValid_b = 1'b0, Repeat_b = 1'b0;
  logic [4:0] GapLen_b = '0;
  logic       SioDat_b, TxAck_b, Busy_b, FrameDone_b;

  bit   drop_a = 1'b0, drop_b = 1'b0;
  exp_t q_a[$];
  exp_t q_b[$];
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   tick_no = 0;

  sio_frame_gen u_dut_a (
    .MCLK(MCLK), .nRESET(nRESET), .SioClk(SioClk), .SioDat(SioDat_a),
    .TxData(TxData_a), .TxValid(TxValid_a), .TxAck(TxAck_a), .Repeat(Repeat_a),
    .GapLen(GapLen_a), .Busy(Busy_a), .FrameDone(FrameDone_a)
  );

  sio_frame_gen #(.DATA_W(8), .GAP_W(5), .PARITY(1), .MSB_FIRST(0)) u_dut_b (
    .MCLK(MCLK), .nRESET(nRESET), .SioClk(SioClk), .SioDat(SioDat_b),
    .TxData(TxData_b), .TxValid(TxValid_b), .TxAck(TxAck_b), .Repeat(Repeat_b),
    .GapLen(GapLen_b), .Busy(Busy_b), .FrameDone(FrameDone_b)
  );

  always #5 MCLK = ~MCLK;

  task automatic push(input bit to_b, input exp_t e);
    if (to_b) q_b.push_back(e);
    else      q_a.push_back(e);
  endtask

  task automatic push_zeros(input bit to_b, input int n);
    for (int i = 0; i < n; i++) push(to_b, 4'b0000);
  endtask

  // Expected periods for one frame: start, data, optional parity, the
  // period that closes the frame (FrameDone) and the reloaded gap.
  task automatic push_frame(input bit to_b, input logic [31:0] word, input int dw,
                            input bit msb, input int par, input bit ack, input int gap);
    logic [31:0] w;
    logic p;
    w = word;
    p = 1'b0;
    push(to_b, {1'b1, 1'b1, 1'b0, ack});
    for (int i = 0; i < dw; i++) begin
      push(to_b, {(msb ? w[dw-1-i] : w[i]), 1'b1, 1'b0, 1'b0});
      p = p ^ w[i];
    end
    if (par != 0) push(to_b, {((par == 2) ? ~p : p), 1'b1, 1'b0, 1'b0});
    push(to_b, 4'b0010);
    push_zeros(to_b, gap);
  endtask

  // One SioClk period; pulses are sampled every MCLK and checked against
  // the head of each scoreboard queue at the end of the period.
  task automatic tick();
    logic [11:0] dm_a, am_a, dm_b, am_b;
    exp_t e;
    dm_a = '0; am_a = '0; dm_b = '0; am_b = '0;
    tick_no++;
    SioClk = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 6) SioClk = 1'b0;
      @(negedge MCLK);
      dm_a[k] = FrameDone_a; am_a[k] = TxAck_a;
      dm_b[k] = FrameDone_b; am_b[k] = TxAck_b;
      if (TxAck_a && drop_a) TxValid_a = 1'b0;
      if (TxAck_b && drop_b) TxValid_b = 1'b0;
    end
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      chk_cnt += 4;
      if (SioDat_a !== e.dat) $display("FAIL a_sio_dat tick %0d: got %b want %b", tick_no, SioDat_a, e.dat);
      else pass_cnt++;
      if (Busy_a !== e.busy) $display("FAIL a_busy tick %0d: got %b want %b", tick_no, Busy_a, e.busy);
      else pass_cnt++;
      if (dm_a !== (e.done ? 12'h004 : 12'h000)) $display("FAIL a_frame_done tick %0d: got %h want %h", tick_no, dm_a, (e.done ? 12'h004 : 12'h000));
      else pass_cnt++;
      if (am_a !== (e.ack ? 12'h004 : 12'h000)) $display("FAIL a_tx_ack tick %0d: got %h want %h", tick_no, am_a, (e.ack ? 12'h004 : 12'h000));
      else pass_cnt++;
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      chk_cnt += 4;
      if (SioDat_b !== e.dat) $display("FAIL b_sio_dat tick %0d: got %b want %b", tick_no, SioDat_b, e.dat);
      else pass_cnt++;
      if (Busy_b !== e.busy) $display("FAIL b_busy tick %0d: got %b want %b", tick_no, Busy_b, e.busy);
      else pass_cnt++;
      if (dm_b !== (e.done ? 12'h004 : 12'h000)) $display("FAIL b_frame_done tick %0d: got %h want %h", tick_no, dm_b, (e.done ? 12'h004 : 12'h000));
      else pass_cnt++;
      if (am_b !== (e.ack ? 12'h004 : 12'h000)) $display("FAIL b_tx_ack tick %0d: got %h want %h", tick_no, am_b, (e.ack ? 12'h004 : 12'h000));
      else pass_cnt++;
    end
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_all();
    int guard;
    guard = 0;
    while ((q_a.size() > 0 || q_b.size() > 0) && guard < 2000) begin
      tick();
      guard++;
    end
    chk_cnt++;
    if (guard >= 2000) $display("FAIL run_all_bound: got %0d ticks, limit 2000", guard);
    else pass_cnt++;
  endtask

  task automatic reset_dut();
    SioClk = 1'b0;
    nRESET = 1'b0;
    TxValid_a = 1'b0; Repeat_a = 1'b0; drop_a = 1'b0;
    TxValid_b = 1'b0; Repeat_b = 1'b0; drop_b = 1'b0;
    repeat (3) @(negedge MCLK);
    q_a.delete();
    q_b.delete();
    nRESET = 1'b1;
    repeat (2) @(negedge MCLK);
  endtask

  task automatic test_reset();
    nRESET = 1'b0;
    SioClk = 1'b0;
    repeat (2) @(negedge MCLK);
    chk_cnt += 8;
    if (SioDat_a !== 1'b0)    $display("FAIL rst_a_dat: got %b want 0", SioDat_a);    else pass_cnt++;
    if (Busy_a !== 1'b0)      $display("FAIL rst_a_busy: got %b want 0", Busy_a);     else pass_cnt++;
    if (TxAck_a !== 1'b0)     $display("FAIL rst_a_ack: got %b want 0", TxAck_a);     else pass_cnt++;
    if (FrameDone_a !== 1'b0) $display("FAIL rst_a_done: got %b want 0", FrameDone_a); else pass_cnt++;
    if (SioDat_b !== 1'b0)    $display("FAIL rst_b_dat: got %b want 0", SioDat_b);    else pass_cnt++;
    if (Busy_b !== 1'b0)      $display("FAIL rst_b_busy: got %b want 0", Busy_b);     else pass_cnt++;
    if (TxAck_b !== 1'b0)     $display("FAIL rst_b_ack: got %b want 0", TxAck_b);     else pass_cnt++;
    if (FrameDone_b !== 1'b0) $display("FAIL rst_b_done: got %b want 0", FrameDone_b); else pass_cnt++;
  endtask

  // Default frames back to back with TxValid held: 21 zeros, frame, 21 zeros...
  task automatic test_back_to_back();
    reset_dut();
    GapLen_a = 5'd20; TxData_a = 10'h355; TxValid_a = 1'b1;
    push_zeros(1'b0, 21);
    push_frame(1'b0, 32'h355, 10, 1'b1, 0, 1'b1, 20);
    push_frame(1'b0, 32'h355, 10, 1'b1, 0, 1'b1, 20);
    run_all();
  endtask

  task automatic test_parity_lsb();
    reset_dut();
    GapLen_b = 5'd2; TxData_b = 8'h01; TxValid_b = 1'b1; drop_b = 1'b1;
    push_zeros(1'b1, 3);
    push_frame(1'b1, 32'h01, 8, 1'b0, 1, 1'b1, 2);
    push_zeros(1'b1, 3);
    run_all();
    TxData_b = 8'hB4; TxValid_b = 1'b1;
    push_frame(1'b1, 32'hB4, 8, 1'b0, 1, 1'b1, 2);
    run_all();
  endtask

  task automatic test_idle_then_valid();
    reset_dut();
    GapLen_a = 5'd3; TxData_a = 10'h2A5; TxValid_a = 1'b1; drop_a = 1'b1;
    push_zeros(1'b0, 4);
    push_frame(1'b0, 32'h2A5, 10, 1'b1, 0, 1'b1, 3);
    push_zeros(1'b0, 12);
    run_all();
    TxData_a = 10'h0F0; TxValid_a = 1'b1;
    push_frame(1'b0, 32'h0F0, 10, 1'b1, 0, 1'b1, 3);
    run_all();
  endtask

  task automatic test_repeat();
    reset_dut();
    Repeat_a = 1'b1; GapLen_a = 5'd2;
    push_zeros(1'b0, 9);
    run_all();
    TxData_a = 10'h1C3; TxValid_a = 1'b1; drop_a = 1'b1;
    push_frame(1'b0, 32'h1C3, 10, 1'b1, 0, 1'b1, 2);
    push_frame(1'b0, 32'h1C3, 10, 1'b1, 0, 1'b0, 2);
    push_frame(1'b0, 32'h1C3, 10, 1'b1, 0, 1'b0, 2);
    run_all();
    TxData_a = 10'h00F; TxValid_a = 1'b1;
    push_frame(1'b0, 32'h00F, 10, 1'b1, 0, 1'b1, 2);
    run_all();
    push_frame(1'b0, 32'h00F, 10, 1'b1, 0, 1'b0, 2);
    run_n(5);
    Repeat_a = 1'b0;
    run_all();
    push_zeros(1'b0, 5);
    run_all();
  endtask

  task automatic test_reset_mid_frame();
    reset_dut();
    GapLen_a = 5'd4; TxData_a = 10'h3E0; TxValid_a = 1'b1;
    push_zeros(1'b0, 5);
    push_frame(1'b0, 32'h3E0, 10, 1'b1, 0, 1'b1, 4);
    run_n(11);
    q_a.delete();
    SioClk = 1'b1;
    @(negedge MCLK);
    nRESET = 1'b0;
    #1;
    chk_cnt += 4;
    if (SioDat_a !== 1'b0)    $display("FAIL midrst_dat: got %b want 0", SioDat_a);     else pass_cnt++;
    if (Busy_a !== 1'b0)      $display("FAIL midrst_busy: got %b want 0", Busy_a);      else pass_cnt++;
    if (FrameDone_a !== 1'b0) $display("FAIL midrst_done: got %b want 0", FrameDone_a); else pass_cnt++;
    if (TxAck_a !== 1'b0)     $display("FAIL midrst_ack: got %b want 0", TxAck_a);      else pass_cnt++;
    SioClk = 1'b0;
    repeat (3) @(negedge MCLK);
    nRESET = 1'b1;
    repeat (2) @(negedge MCLK);
    push_zeros(1'b0, 5);
    push_frame(1'b0, 32'h3E0, 10, 1'b1, 0, 1'b1, 4);
    run_all();
  endtask

  task automatic test_gap_change();
    reset_dut();
    GapLen_a = 5'd20; TxData_a = 10'h355; TxValid_a = 1'b1;
    push_zeros(1'b0, 21);
    push_frame(1'b0, 32'h355, 10, 1'b1, 0, 1'b1, 3);
    push_frame(1'b0, 32'h355, 10, 1'b1, 0, 1'b1, 9);
    run_n(25);
    GapLen_a = 5'd3;
    run_n(8);
    GapLen_a = 5'd9;
    run_all();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_parity_lsb();
    test_idle_then_valid();
    test_repeat();
    test_reset_mid_frame();
    test_gap_change();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
